l1_uc_arbiter: RTL and testbench
================================

# l1_uc_arbiter

Two-requester arbiter that shares the single L2/memory-side transfer channel (txrx_buffer controller port) between the L1 instruction cache (requester 0) and the L1 data cache (requester 1). It replaces static done-flag priority with registered round-robin grants held for a whole transaction, muxes the handshake both ways, and flags transactions that never complete. It sits inside the internal memory controller, between the L1 `uc` ports and the buffer.

## Interface
Parameters:
- TIMEOUT, 4096: cycles a grant may stay in GRANT without `m_done_i` before `timeout_o` sets; 0 disables.
- TW, 16: width of the timeout counter.

Ports (n = 0 for L1I, n = 1 for L1D):
- clock_i  in  1  single system clock, all logic on the rising edge
- reset_i  in  1  reset, synchronous and active-high
- rN_req_i  in  1  transaction request, held until the done pulse
- rN_block_i  in  1  block transfer (vs single word)
- rN_rw_i  in  1  1 = write, 0 = read
- rN_add_i  in  24  word address
- rN_data_i  in  32  write data
- rN_write_i  in  1  write-word strobe
- rN_read_i  in  1  read-word acknowledge
- rN_grant_o  out  1  requester owns the channel
- rN_write_ready_o  out  1  downstream can accept a write word
- rN_read_ready_o  out  1  downstream read word valid
- rN_data_o  out  32  read data
- rN_done_o  out  1  transaction complete pulse
- m_req_o, m_block_o, m_rw_o  out  1 each  to buffer
- m_add_o  out  24  to buffer
- m_data_o  out  32  to buffer
- m_write_o, m_read_o  out  1 each  to buffer
- m_write_ready_i, m_read_ready_i, m_done_i  in  1 each  from buffer
- m_data_i  in  32  from buffer
- owner_o  out  1  last granted requester (0 = L1I, 1 = L1D)
- timeout_o  out  1  sticky watchdog flag

## Operation
States:
- IDLE:
  - If either request is high, go to GRANT and latch the owner.
  - If both are high, the winner is the requester that is not `owner_o`.
  - `owner_o` updates at the same edge.
- GRANT:
  - `rX_grant_o` is 1 for the owner.
  - `m_req_o`, `m_block_o`, `m_rw_o`, `m_add_o`, `m_data_o`, `m_write_o` and `m_read_o` are driven combinationally from the owner's inputs.
  - The owner's `rX_write_ready_o`, `rX_read_ready_o`, `rX_data_o` and `rX_done_o` are driven combinationally from `m_write_ready_i`, `m_read_ready_i`, `m_data_i` and `m_done_i`.
  - The non-owner sees all outputs at 0.
  - When `m_done_i` is 1, go to RELEASE.
- RELEASE:
  - All `m_*` outputs are forced to 0. Grant stays with the owner. `rX_done_o` is 0.
  - While the owner's `req_i` is still 1, stay in RELEASE.
  - When the owner's `req_i` is 0, arbitrate that same cycle exactly as in IDLE. Go to GRANT for the other requester if it is requesting, otherwise to IDLE.

Rules:
- The owner dropping `req_i` before `m_done_i` does not release the grant. `m_req_o` follows `req_i`; the grant is held until `m_done_i`.
- `m_done_i` in IDLE or RELEASE is ignored.
- Timeout counter:
  - Clears on entry to GRANT and increments each GRANT cycle, saturating at 2^TW−1.
  - When the count equals TIMEOUT (TIMEOUT≠0), `timeout_o` sets and stays 1 until reset.
  - The grant is not aborted.
- Reset state: IDLE, `owner_o`=1 (L1I wins the first tie), counter 0, `timeout_o` 0. All outputs are 0 in the cycle after reset is sampled.
- Reset mid-transaction abandons the transfer with no done pulse.

## Timing
- Request latency: `req_i` is sampled high at edge k; `grant_o` and `m_req_o` are high from cycle k+1.
- All handshake paths through the arbiter (ready, data, strobes, done) are combinational: zero added latency in GRANT.
- Done to release: a done pulse in cycle d enters RELEASE at d+1.
  - If the owner's req is low at d+1 and the other requester is pending, the other requester's grant is high at d+2.
  - Back-to-back switch costs exactly 1 dead cycle.
- A single requester re-requesting after RELEASE also passes through IDLE (or RELEASE arbitration). There is a minimum of 1 dead cycle between transactions.
- Outputs are registered state decoded combinationally. No output toggles while in IDLE.

## Test plan
- Reset, then r0 requests a single-word read: `r0_grant_o`=1 at the next cycle, `m_add_o`=r0_add_i. `m_data_i`=0xDEADBEEF with `m_read_ready_i`=1 gives `r0_data_o`=0xDEADBEEF and `r1_data_o`=0. Done gives RELEASE, then IDLE when `r0_req_i` drops.
- r0 and r1 request simultaneously after reset: r0 is granted first (`owner_o`=0). After r0 completes and drops req, `r1_grant_o`=1 exactly 2 cycles after the done pulse.
- Both hold requests continuously with requesters re-raising req: the grant sequence alternates 0,1,0,1 over 4 transactions, with no requester served twice in a row.
- r1 4-word block write: 4 `m_write_o` strobes pass with `m_data_o` equal to r1_data_i each cycle. r0 requesting mid-transfer gets no grant until after the r1 done pulse.
- TIMEOUT=8, grant with no `m_done_i`: `timeout_o`=1 at the 8th GRANT cycle and stays 1. A later done completes normally; `timeout_o` clears only on reset.
- `reset_i` pulsed while in GRANT: next cycle all grants, `m_req_o` and `timeout_o` are 0 and the state is IDLE. A following tie is granted to r0.

Source files
------------

// File: rtl/l1_uc_arbiter_if.sv
// Transfer-channel bundle shared by the L1 uc ports and the txrx_buffer controller port.
// The master side issues transactions; the slave side answers and, toward an L1 cache, grants.
interface l1_uc_arbiter_if;
  logic        req;
  logic        block;
  logic        rw;
  logic [23:0] add;
  logic [31:0] wData;
  logic        write;
  logic        read;
  logic        grant;
  logic        writeReady;
  logic        readReady;
  logic [31:0] rData;
  logic        done;

  modport master (
    output req, block, rw, add, wData, write, read,
    input  writeReady, readReady, rData, done
  );

  modport slave (
    input  req, block, rw, add, wData, write, read,
    output grant, writeReady, readReady, rData, done
  );
endinterface

// File: rtl/l1_uc_arbiter.sv
// Round-robin arbiter giving L1I (r0) or L1D (r1) the single buffer channel for a whole
// transaction, with a sticky watchdog flag for grants that never see a done pulse.
module l1_uc_arbiter #(
  parameter int TIMEOUT = 4096,
  parameter int TW      = 16
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  l1_uc_arbiter_if.slave        r0,
  l1_uc_arbiter_if.slave        r1,
  l1_uc_arbiter_if.master       m,
  output logic                  owner_o,
  output logic                  timeout_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam bit            TIMEOUT_EN = (TIMEOUT != 0);
  localparam logic [TW-1:0] CNT_MAX    = '1;
  // The counter holds completed GRANT cycles, so the TIMEOUT-th cycle is seen at TIMEOUT-1.
  localparam logic [TW-1:0] CNT_HIT    = TW'(TIMEOUT - 1);

  state_t        state;
  logic          owner;
  logic          timeoutSticky;
  logic [TW-1:0] cnt;

  logic anyReq;
  logic ownerReq;
  logic pick;
  logic timeoutHit;

  assign anyReq   = r0.req | r1.req;
  assign ownerReq = owner ? r1.req : r0.req;
  // On a tie the requester that did not own the channel last time wins.
  assign pick     = (r0.req & r1.req) ? ~owner : r1.req;
  assign timeoutHit = TIMEOUT_EN && (state == GRANT) && (cnt == CNT_HIT);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state         <= IDLE;
      owner         <= 1'b1;
      cnt           <= '0;
      timeoutSticky <= 1'b0;
    end else begin
      if (timeoutHit) timeoutSticky <= 1'b1;
      unique case (state)
        IDLE: begin
          if (anyReq) begin
            state <= GRANT;
            owner <= pick;
            cnt   <= '0;
          end
        end
        GRANT: begin
          if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          if (m.done) state <= RELEASE;
        end
        RELEASE: begin
          if (!ownerReq) begin
            if (anyReq) begin
              state <= GRANT;
              owner <= pick;
              cnt   <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign owner_o   = owner;
  assign timeout_o = timeoutSticky | timeoutHit;
  assign r0.grant  = (state != IDLE) && !owner;
  assign r1.grant  = (state != IDLE) &&  owner;

  // NOTE: every output gets a default before the case logic, so no latch can be inferred.
  always_comb begin
    m.req         = 1'b0;
    m.block       = 1'b0;
    m.rw          = 1'b0;
    m.add         = '0;
    m.wData       = '0;
    m.write       = 1'b0;
    m.read        = 1'b0;
    r0.writeReady = 1'b0;
    r0.readReady  = 1'b0;
    r0.rData      = '0;
    r0.done       = 1'b0;
    r1.writeReady = 1'b0;
    r1.readReady  = 1'b0;
    r1.rData      = '0;
    r1.done       = 1'b0;
    if (state == GRANT) begin
      if (owner) begin
        m.req         = r1.req;
        m.block       = r1.block;
        m.rw          = r1.rw;
        m.add         = r1.add;
        m.wData       = r1.wData;
        m.write       = r1.write;
        m.read        = r1.read;
        r1.writeReady = m.writeReady;
        r1.readReady  = m.readReady;
        r1.rData      = m.rData;
        r1.done       = m.done;
      end else begin
        m.req         = r0.req;
        m.block       = r0.block;
        m.rw          = r0.rw;
        m.add         = r0.add;
        m.wData       = r0.wData;
        m.write       = r0.write;
        m.read        = r0.read;
        r0.writeReady = m.writeReady;
        r0.readReady  = m.readReady;
        r0.rData      = m.rData;
        r0.done       = m.done;
      end
    end
  end

  // Both L1 caches must never see the channel at the same time.
  assert property (@(posedge clock_i) disable iff (reset_i) !(r0.grant && r1.grant));
  // A done pulse reaches at most one requester.
  assert property (@(posedge clock_i) disable iff (reset_i) !(r0.done && r1.done));

endmodule

// File: tb/tb_l1_uc_arbiter.sv
// Directed bench for l1_uc_arbiter: stimulus pushes expected grants, reads and writes into
// queues that independent negedge monitors pop and compare.
module tb_l1_uc_arbiter;

  logic clock_i = 1'b0;
  logic reset_i = 1'b1;
  logic owner_o;
  logic timeout_o;

  always #5 clock_i = ~clock_i;

  l1_uc_arbiter_if r0If ();
  l1_uc_arbiter_if r1If ();
  l1_uc_arbiter_if mIf ();

  assign mIf.grant = 1'b0;

  l1_uc_arbiter #(.TIMEOUT(8), .TW(16)) dut (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .r0        (r0If),
    .r1        (r1If),
    .m         (mIf),
    .owner_o   (owner_o),
    .timeout_o (timeout_o)
  );

  typedef struct { int id; int cyc; } grant_t;
  typedef struct { int id; logic [31:0] data; } read_t;

  grant_t      grantQ[$];
  read_t       readQ[$];
  logic [31:0] writeQ[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clock_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic popGrant(input int id);
    grant_t g;
    if (grantQ.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected grant: requester %0d granted at cycle %0d, none expected", id, cyc);
    end else begin
      g = grantQ.pop_front();
      check("grant id", 32'(id), 32'(g.id));
      check("grant cycle", 32'(cyc), 32'(g.cyc));
    end
  endtask

  // Grant monitor: compares every rising grant against the scoreboard.
  logic g0q = 1'b0;
  logic g1q = 1'b0;
  always @(negedge clock_i) begin
    if (r0If.grant && !g0q) popGrant(0);
    if (r1If.grant && !g1q) popGrant(1);
    g0q = r0If.grant;
    g1q = r1If.grant;
  end

  // Read monitor: a valid read word at an L1 port must match the queued word, other port silent.
  always @(negedge clock_i) begin
    read_t r;
    if (r0If.readReady || r1If.readReady) begin
      if (readQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected read word at cycle %0d", cyc);
      end else begin
        r = readQ.pop_front();
        check("read port", 32'(r1If.readReady), 32'(r.id));
        check("read data", r.id == 1 ? r1If.rData : r0If.rData, r.data);
        check("other port data", r.id == 1 ? r0If.rData : r1If.rData, 32'h0);
      end
    end
  end

  // Write monitor: every write strobe toward the buffer carries the queued word.
  always @(negedge clock_i) begin
    logic [31:0] w;
    if (mIf.write) begin
      if (writeQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected write strobe at cycle %0d", cyc);
      end else begin
        w = writeQ.pop_front();
        check("write data", mIf.wData, w);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock_i);
      #1;
    end
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic setReq(input int id, input logic v);
    if (id == 1) r1If.req = v;
    else         r0If.req = v;
  endtask

  task automatic clearAll();
    r0If.req = 0; r0If.block = 0; r0If.rw = 0; r0If.add = '0; r0If.wData = '0;
    r0If.write = 0; r0If.read = 0;
    r1If.req = 0; r1If.block = 0; r1If.rw = 0; r1If.add = '0; r1If.wData = '0;
    r1If.write = 0; r1If.read = 0;
    mIf.writeReady = 0; mIf.readReady = 0; mIf.rData = '0; mIf.done = 0;
  endtask

  task automatic doReset();
    reset_i = 1'b1;
    step(2);
    reset_i = 1'b0;
  endtask

  initial begin
    int d;
    clearAll();
    doReset();
    settle();
    check("reset r0 grant", 32'(r0If.grant), 32'h0);
    check("reset r1 grant", 32'(r1If.grant), 32'h0);
    check("reset m_req", 32'(mIf.req), 32'h0);
    check("reset timeout", 32'(timeout_o), 32'h0);
    check("reset owner", 32'(owner_o), 32'h1);

    // r0 single-word read.
    r0If.req = 1; r0If.add = 24'h123456;
    grantQ.push_back('{id: 0, cyc: cyc + 1});
    step();
    check("t1 m_add", 32'(mIf.add), 32'h0012_3456);
    check("t1 m_req", 32'(mIf.req), 32'h1);
    mIf.rData = 32'hDEADBEEF; mIf.readReady = 1; r0If.read = 1;
    readQ.push_back('{id: 0, data: 32'hDEADBEEF});
    settle();
    check("t1 m_read", 32'(mIf.read), 32'h1);
    step();
    mIf.readReady = 0; r0If.read = 0; mIf.rData = '0; mIf.done = 1;
    settle();
    check("t1 r0 done", 32'(r0If.done), 32'h1);
    check("t1 r1 done", 32'(r1If.done), 32'h0);
    step();
    mIf.done = 0;
    settle();
    check("t1 release grant", 32'(r0If.grant), 32'h1);
    check("t1 release m_req", 32'(mIf.req), 32'h0);
    check("t1 release done", 32'(r0If.done), 32'h0);
    r0If.req = 0;
    step();
    check("t1 idle grant", 32'(r0If.grant), 32'h0);

    // Tie after reset goes to r0; r1 follows exactly 2 cycles after done.
    doReset();
    r0If.req = 1; r1If.req = 1;
    grantQ.push_back('{id: 0, cyc: cyc + 1});
    step();
    check("t2 owner", 32'(owner_o), 32'h0);
    mIf.done = 1; d = cyc;
    step();
    mIf.done = 0; r0If.req = 0;
    grantQ.push_back('{id: 1, cyc: d + 2});
    step();
    mIf.done = 1;
    step();
    mIf.done = 0; r1If.req = 0;
    step();

    // Continuous contention alternates 0,1,0,1.
    r0If.req = 1; r1If.req = 1;
    grantQ.push_back('{id: 0, cyc: cyc + 1});
    step();
    for (int i = 0; i < 4; i++) begin
      int who;
      who = i % 2;
      mIf.done = 1; d = cyc;
      step();
      mIf.done = 0;
      setReq(who, 1'b0);
      if (i < 3) grantQ.push_back('{id: 1 - who, cyc: d + 2});
      else       setReq(1 - who, 1'b0);
      step();
      setReq(who, i < 3);
    end
    step();

    // r1 4-word block write; r0 asks mid-transfer and must wait.
    r1If.req = 1; r1If.block = 1; r1If.rw = 1; r1If.add = 24'h000400;
    grantQ.push_back('{id: 1, cyc: cyc + 1});
    step();
    for (int k = 0; k < 4; k++) begin
      r1If.wData = 32'hA000_0000 + 32'(k);
      r1If.write = 1; mIf.writeReady = 1;
      writeQ.push_back(32'hA000_0000 + 32'(k));
      if (k == 1) r0If.req = 1;
      settle();
      check("t4 write ready", 32'(r1If.writeReady), 32'h1);
      step();
    end
    r1If.write = 0; mIf.writeReady = 0;
    settle();
    check("t4 r0 waits", 32'(r0If.grant), 32'h0);
    mIf.done = 1; d = cyc;
    step();
    mIf.done = 0; r1If.req = 0; r1If.block = 0; r1If.rw = 0;
    grantQ.push_back('{id: 0, cyc: d + 2});
    step();
    mIf.done = 1;
    step();
    mIf.done = 0; r0If.req = 0;
    step();

    // Watchdog: no done for 10 GRANT cycles, flag rises on the 8th and sticks.
    r0If.req = 1;
    grantQ.push_back('{id: 0, cyc: cyc + 1});
    step();
    for (int c = 1; c <= 10; c++) begin
      check($sformatf("t5 timeout c%0d", c), 32'(timeout_o), 32'(c >= 8));
      step();
    end
    mIf.done = 1;
    step();
    mIf.done = 0;
    settle();
    check("t5 timeout release", 32'(timeout_o), 32'h1);
    r0If.req = 0;
    step();
    check("t5 timeout idle", 32'(timeout_o), 32'h1);
    check("t5 idle grant", 32'(r0If.grant), 32'h0);

    // Reset in GRANT abandons the transfer; a following tie goes to r0.
    r1If.req = 1;
    grantQ.push_back('{id: 1, cyc: cyc + 1});
    step();
    reset_i = 1;
    step();
    reset_i = 0;
    settle();
    check("t6 r0 grant", 32'(r0If.grant), 32'h0);
    check("t6 r1 grant", 32'(r1If.grant), 32'h0);
    check("t6 m_req", 32'(mIf.req), 32'h0);
    check("t6 timeout", 32'(timeout_o), 32'h0);
    check("t6 r1 done", 32'(r1If.done), 32'h0);
    r0If.req = 1;
    grantQ.push_back('{id: 0, cyc: cyc + 1});
    step();
    check("t6 owner", 32'(owner_o), 32'h0);
    mIf.done = 1; d = cyc;
    step();
    mIf.done = 0; r0If.req = 0;
    grantQ.push_back('{id: 1, cyc: d + 2});
    step();
    mIf.done = 1;
    step();
    mIf.done = 0; r1If.req = 0;
    step(2);

    check("grant queue drained", 32'(grantQ.size()), 32'h0);
    check("read queue drained", 32'(readQ.size()), 32'h0);
    check("write queue drained", 32'(writeQ.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
